mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
Multi-cycle MIPS main control FSM. Decodes the 6-bit opcode of the instruction in the IR and sequences the datapath through fetch/decode/execute/memory/writeback. Drives ALUOp, which alu_control_unit combines with funct to form ALUctrl. Includes a ready handshake and timeout toward instruction/data memory.

Parameters:
MEM_TIMEOUT, 255, max cycles waiting for mem_ready in any memory state; 0 disables timeout
TO_W, 8, width of wait counter; must satisfy MEM_TIMEOUT < 2**TO_W

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
opcode  input  6  IR[31:26]
mem_ready  input  1  memory completes current read/write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU zero
IorD  output  1  0=PC address, 1=ALUOut address
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  IR load
MemtoReg  output  1  1=MDR to register file
RegDst  output  1  1=rd, 0=rt
RegWrite  output  1  register file write
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
ALUOp  output  2  00=add, 01=sub, 10=use funct
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
instr_done  output  1  one-cycle pulse in final cycle of each instruction
illegal_op  output  1  one-cycle pulse, unsupported opcode
mem_error  output  1  one-cycle pulse, memory timeout
state_o  output  4  current state encoding (debug)

Behaviour:
- Single state register plus TO_W-bit wait counter; all updates on rising clk. rst_n=0 at an edge: state<=FETCH, counter<=0; overrides any in-flight operation, including mid-MEMRD/MEMWR.
- Outputs are decoded from state (plus mem_ready/opcode where noted); signals not listed for a state are 0.
- Post-reset outputs (state FETCH, mem_ready=0): MemRead=1, ALUSrcB=01; all others 0, state_o=0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=1 only in the cycle mem_ready=1, then ->DECODE; otherwise hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Opcode 100011/101011 ->MEMADR; 000000 ->EXEC; 000100 ->BRANCH; 000010 ->JUMP; 001000 ->ADDIEX; other: illegal_op=1, instr_done=1, ->FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw ->MEMRD, sw ->MEMWR (opcode held stable by IR).
- MEMRD: MemRead=1, IorD=1; mem_ready ->MEMWB, else hold.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1 ->FETCH.
- MEMWR: MemWrite=1, IorD=1; mem_ready: instr_done=1 ->FETCH, else hold.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 ->ALUWB. ALUWB: RegDst=1, RegWrite=1, instr_done=1 ->FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 ->ADDIWB. ADDIWB: RegDst=0, RegWrite=1, instr_done=1 ->FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1 ->FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1 ->FETCH.
- Latencies (zero-wait memory): R/addi/lw-less 4 cycles; lw 5; sw 4; beq/j 3.
- Wait counter: cleared on entry to FETCH/MEMRD/MEMWR and whenever mem_ready=1; increments each waiting cycle. If MEM_TIMEOUT!=0 and counter==MEM_TIMEOUT with mem_ready=0: mem_error=1, request deasserted next cycle, ->FETCH (no IRWrite/PCWrite/RegWrite). mem_ready in the same cycle wins over timeout.
- mem_ready outside FETCH/MEMRD/MEMWR ignored.

Decomposition:
- Package mips_ctrl_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), ALUOp codes, ALUSrcB/PCSource codes, 4-bit state encoding (FETCH=0 ... ADDIWB=11).
- No sub-module; next-state and output decode in one module.

Test Plan:
- Reset then opcode 000000, mem_ready=1 always -> states FETCH,DECODE,EXEC,ALUWB; ALUOp=10 in EXEC; RegWrite=RegDst=1 and instr_done in cycle 4.
- lw (100011), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles with MemRead=IorD=1; MEMWB asserts MemtoReg=RegWrite=1; total 8 cycles.
- beq (000100) -> 3 cycles; BRANCH shows ALUOp=01, PCWriteCond=1, PCSource=01; j (000010) -> PCWrite=1, PCSource=10.
- Opcode 111111 -> illegal_op and instr_done pulse in DECODE, FETCH next; no RegWrite/MemWrite ever.
- MEM_TIMEOUT=4, sw with mem_ready stuck 0 -> mem_error pulse after 4 waiting cycles in MEMWR, MemWrite=0 next cycle, state FETCH.
- rst_n=0 for one edge during MEMRD -> next cycle state_o=0, MemRead=1, IorD=0, all write enables 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM: opcodes,
// datapath mux codes, state encoding and the packed control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_error;
  } ctrl_t;

  // States that wait on the memory handshake and are guarded by the timeout.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM with memory ready handshake and
// optional wait timeout. Three processes: register, next state, outputs.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_error,
  output logic [3:0] state_o
);

  localparam bit              TO_EN    = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_t          state_reg, state_next;
  logic [TO_W-1:0] cnt_reg, cnt_next;
  logic            mem_wait;
  logic            timeout;
  ctrl_t           ctrl;

  // mem_ready in the same cycle always beats the timeout.
  assign mem_wait = is_mem_state(state_reg) && !mem_ready;
  assign timeout  = TO_EN && mem_wait && (cnt_reg == TO_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= FETCH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    // Counter only runs while stalled; any transition or handshake clears it.
    if (mem_wait && !timeout) begin
      cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
    end
    case (state_reg)
      FETCH: begin
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXEC;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
          OP_ADDI:      state_next = ADDIEX;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR: state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        if (mem_ready)    state_next = MEMWB;
        else if (timeout) state_next = FETCH;
      end
      MEMWR: begin
        if (mem_ready || timeout) state_next = FETCH;
      end
      MEMWB:   state_next = FETCH;
      EXEC:    state_next = ALUWB;
      ALUWB:   state_next = FETCH;
      ADDIEX:  state_next = ADDIWB;
      ADDIWB:  state_next = FETCH;
      BRANCH:  state_next = FETCH;
      JUMP:    state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    ctrl           = '0;
    ctrl.mem_error = timeout;
    case (state_reg)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: ;
          default: begin
            ctrl.illegal_op = 1'b1;
            ctrl.instr_done = 1'b1;
          end
        endcase
      end
      MEMADR, ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign instr_done  = ctrl.instr_done;
  assign illegal_op  = ctrl.illegal_op;
  assign mem_error   = ctrl.mem_error;
  assign state_o     = state_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed vector table plus randomized instruction stream checked against
// an instruction-sequence model of the control FSM.
module tb_mips_multicycle_control;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       instr_done, illegal_op, mem_error;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_control #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_error(mem_error),
    .state_o(state_o)
  );

  // Bit layout: pcw pcwc iord mrd mwr irw m2r rdst rw srca srcb aluop pcsrc done ill merr state
  logic [22:0] actual;
  assign actual = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                   instr_done, illegal_op, mem_error, state_o};

  function automatic logic [22:0] cw(input int st, input int pcw, input int pcwc,
      input int iord, input int mrd, input int mwr, input int irw, input int m2r,
      input int rdst, input int rw, input int srca, input int srcb, input int aluop,
      input int pcsrc, input int done, input int ill, input int merr);
    return {pcw[0], pcwc[0], iord[0], mrd[0], mwr[0], irw[0], m2r[0], rdst[0], rw[0],
            srca[0], srcb[1:0], aluop[1:0], pcsrc[1:0], done[0], ill[0], merr[0], st[3:0]};
  endfunction

  task automatic check(input string name, input logic [22:0] exp);
    checks++;
    if (actual !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (state %0d vs %0d)", name, actual, exp,
               actual[3:0], exp[3:0]);
    end
  endtask

  // Control words of each state with mem_ready low and no pulses.
  function automatic logic [22:0] base_of(input int s);
    case (s)
      0:  return cw(0, 0,0,0,1,0,0,0,0,0,0, 1,0,0, 0,0,0);
      1:  return cw(1, 0,0,0,0,0,0,0,0,0,0, 3,0,0, 0,0,0);
      2:  return cw(2, 0,0,0,0,0,0,0,0,0,1, 2,0,0, 0,0,0);
      3:  return cw(3, 0,0,1,1,0,0,0,0,0,0, 0,0,0, 0,0,0);
      4:  return cw(4, 0,0,0,0,0,0,1,0,1,0, 0,0,0, 0,0,0);
      5:  return cw(5, 0,0,1,0,1,0,0,0,0,0, 0,0,0, 0,0,0);
      6:  return cw(6, 0,0,0,0,0,0,0,0,0,1, 0,2,0, 0,0,0);
      7:  return cw(7, 0,0,0,0,0,0,0,1,1,0, 0,0,0, 0,0,0);
      8:  return cw(8, 0,1,0,0,0,0,0,0,0,1, 0,1,1, 0,0,0);
      9:  return cw(9, 1,0,0,0,0,0,0,0,0,0, 0,0,2, 0,0,0);
      10: return cw(10,0,0,0,0,0,0,0,0,0,1, 2,0,0, 0,0,0);
      default: return cw(11,0,0,0,0,0,0,0,0,1,0, 0,0,0, 0,0,0);
    endcase
  endfunction

  typedef struct {
    logic       rst_n;
    logic [5:0] op;
    logic       mr;
    bit         chk;
    logic [22:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [5:0] op, input logic mr, input bit chk,
                     input logic [22:0] exp);
    vec_t v;
    v.rst_n = r; v.op = op; v.mr = mr; v.chk = chk; v.exp = exp;
    vq.push_back(v);
  endtask

  // Instruction kinds as state-visit sequences.
  int seq[7][5] = '{'{0,1,6,7,0}, '{0,1,2,3,4}, '{0,1,2,5,0}, '{0,1,8,0,0},
                    '{0,1,9,0,0}, '{0,1,10,11,0}, '{0,1,0,0,0}};
  int len[7] = '{4, 5, 4, 3, 3, 4, 2};

  function automatic int kind_of(input logic [5:0] op);
    case (op)
      6'b000000: return 0;
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b000010: return 4;
      6'b001000: return 5;
      default:   return 6;
    endcase
  endfunction

  initial begin
    logic [22:0] fi, fg, dec, madr, mrd, mwr;
    logic [5:0]  cur_op;
    int kind, step, w, s, prob, ncyc;
    bit is_mem, last, need_op;
    logic [22:0] exp;

    fi   = base_of(0);
    fg   = cw(0, 1,0,0,1,0,1,0,0,0,0, 1,0,0, 0,0,0);
    dec  = base_of(1);
    madr = base_of(2);
    mrd  = base_of(3);
    mwr  = base_of(5);

    add(0, 6'h00, 0, 0, fi);
    add(1, 6'h00, 0, 1, fi);
    // R-type
    add(1, 6'h00, 1, 1, fg);
    add(1, 6'h00, 1, 1, dec);
    add(1, 6'h00, 1, 1, cw(6, 0,0,0,0,0,0,0,0,0,1, 0,2,0, 0,0,0));
    add(1, 6'h00, 1, 1, cw(7, 0,0,0,0,0,0,0,1,1,0, 0,0,0, 1,0,0));
    // beq
    add(1, 6'h04, 1, 1, fg);
    add(1, 6'h04, 1, 1, dec);
    add(1, 6'h04, 1, 1, cw(8, 0,1,0,0,0,0,0,0,0,1, 0,1,1, 1,0,0));
    // j
    add(1, 6'h02, 1, 1, fg);
    add(1, 6'h02, 1, 1, dec);
    add(1, 6'h02, 1, 1, cw(9, 1,0,0,0,0,0,0,0,0,0, 0,0,2, 1,0,0));
    // illegal opcode
    add(1, 6'h3F, 1, 1, fg);
    add(1, 6'h3F, 1, 1, cw(1, 0,0,0,0,0,0,0,0,0,0, 3,0,0, 1,1,0));
    add(1, 6'h3F, 0, 1, fi);
    // lw with three wait cycles in MEMRD: 8 cycles total
    add(1, 6'h23, 1, 1, fg);
    add(1, 6'h23, 1, 1, dec);
    add(1, 6'h23, 1, 1, madr);
    add(1, 6'h23, 0, 1, mrd);
    add(1, 6'h23, 0, 1, mrd);
    add(1, 6'h23, 0, 1, mrd);
    add(1, 6'h23, 1, 1, mrd);
    add(1, 6'h23, 1, 1, cw(4, 0,0,0,0,0,0,1,0,1,0, 0,0,0, 1,0,0));
    // sw with stuck memory: timeout after 4 waiting cycles
    add(1, 6'h2B, 1, 1, fg);
    add(1, 6'h2B, 1, 1, dec);
    add(1, 6'h2B, 1, 1, madr);
    for (int i = 0; i < TO; i++) add(1, 6'h2B, 0, 1, mwr);
    add(1, 6'h2B, 0, 1, cw(5, 0,0,1,0,1,0,0,0,0,0, 0,0,0, 0,0,1));
    add(1, 6'h2B, 0, 1, fi);
    // addi
    add(1, 6'h08, 1, 1, fg);
    add(1, 6'h08, 1, 1, dec);
    add(1, 6'h08, 1, 1, cw(10, 0,0,0,0,0,0,0,0,0,1, 2,0,0, 0,0,0));
    add(1, 6'h08, 1, 1, cw(11, 0,0,0,0,0,0,0,0,1,0, 0,0,0, 1,0,0));
    // sw zero-wait
    add(1, 6'h2B, 1, 1, fg);
    add(1, 6'h2B, 1, 1, dec);
    add(1, 6'h2B, 1, 1, madr);
    add(1, 6'h2B, 1, 1, cw(5, 0,0,1,0,1,0,0,0,0,0, 0,0,0, 1,0,0));
    // reset in the middle of MEMRD
    add(1, 6'h23, 1, 1, fg);
    add(1, 6'h23, 1, 1, dec);
    add(1, 6'h23, 1, 1, madr);
    add(0, 6'h23, 0, 1, mrd);
    add(1, 6'h23, 0, 1, fi);

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n; opcode = vq[i].op; mem_ready = vq[i].mr;
      #1;
      if (vq[i].chk) begin
        check($sformatf("vec%0d", i), vq[i].exp);
        $display("vec %0d rst_n=%0b op=%h mr=%0b state=%0d", i, vq[i].rst_n, vq[i].op,
                 vq[i].mr, state_o);
      end
      @(posedge clk); #1;
    end

    // Randomized instruction stream against the sequence model
    rst_n = 0; mem_ready = 0;
    @(posedge clk); #1;
    kind = 0; step = 0; w = 0; need_op = 1; cur_op = 6'h00; prob = 100; ncyc = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (need_op) begin
        case ($urandom_range(0, 6))
          0: cur_op = 6'h00;
          1: cur_op = 6'h23;
          2: cur_op = 6'h2B;
          3: cur_op = 6'h04;
          4: cur_op = 6'h02;
          5: cur_op = 6'h08;
          default: begin
            cur_op = 6'($urandom_range(0, 63));
            while (kind_of(cur_op) != 6) cur_op = 6'($urandom_range(0, 63));
          end
        endcase
        kind = kind_of(cur_op);
        case ($urandom_range(0, 2))
          0: prob = 15;
          1: prob = 60;
          default: prob = 100;
        endcase
        need_op = 0; ncyc = 0;
      end
      rst_n = ($urandom_range(0, 299) != 0);
      mem_ready = ($urandom_range(0, 99) < prob);
      opcode = cur_op;
      #1;
      s = seq[kind][step];
      is_mem = (s == 0) || (s == 3) || (s == 5);
      last = (step == len[kind] - 1);
      exp = base_of(s);
      if (s == 0 && mem_ready) begin exp[22] = 1'b1; exp[17] = 1'b1; end
      exp[6] = last && (!is_mem || mem_ready);
      exp[5] = (kind == 6) && (step == 1);
      exp[4] = is_mem && !mem_ready && (w == TO);
      check("rand", exp);
      ncyc++;
      if (!rst_n) begin
        step = 0; w = 0; need_op = 1;
        $display("rand reset op=%h", cur_op);
      end else if (is_mem && !mem_ready) begin
        if (w == TO) begin
          step = 0; w = 0; need_op = (s != 0);
          $display("rand timeout op=%h state=%0d", cur_op, s);
        end else begin
          w++;
        end
      end else begin
        w = 0;
        if (last) begin
          step = 0; need_op = 1;
          $display("rand instr op=%h kind=%0d cycles=%0d", cur_op, kind, ncyc);
        end else begin
          step++;
        end
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
